// File: rtl/fault_ru_allocator_if.sv
// Handshake and result bus between the RU allocator and its control/consumer logic.
interface fault_ru_allocator_if #(
   parameter int unsigned ROWS   = 4,
   parameter int unsigned COLS   = 4,
   parameter int unsigned NUM_RU = 4
);
   localparam int unsigned MAP_W = $clog2(COLS);
   localparam int unsigned CNT_W = $clog2(ROWS*COLS) + 1;

   logic                      start;
   logic [ROWS*COLS-1:0]      STW_result_mat;
   logic [MAP_W*NUM_RU-1:0]   ru_row_mapping;
   logic [MAP_W*NUM_RU-1:0]   ru_col_mapping;
   logic [NUM_RU-1:0]         ru_enable;
   logic [CNT_W-1:0]          fault_count;
   logic                      alloc_overflow;
   logic                      busy;
   logic                      alloc_done;

   modport master (
      output start, STW_result_mat,
      input  ru_row_mapping, ru_col_mapping, ru_enable, fault_count,
             alloc_overflow, busy, alloc_done
   );

   modport slave (
      input  start, STW_result_mat,
      output ru_row_mapping, ru_col_mapping, ru_enable, fault_count,
             alloc_overflow, busy, alloc_done
   );
endinterface

// File: rtl/fault_ru_allocator.sv
// Redundant-unit allocator: scans a snapshot of per-PE self-test results one PE
// per cycle in row-major order and maps each faulty PE onto the next free RU.
module fault_ru_allocator #(
   parameter int unsigned ROWS   = 4,
   parameter int unsigned COLS   = 4,
   parameter int unsigned NUM_RU = 4
) (
   input logic                  clk,
   input logic                  rst,
   fault_ru_allocator_if.slave  bus
);
   localparam int unsigned NUM_PE = ROWS * COLS;
   localparam int unsigned IDX_W  = $clog2(NUM_PE);
   localparam int unsigned PTR_W  = $clog2(NUM_RU) + 1;
   localparam int unsigned MAP_W  = $clog2(COLS);
   localparam int unsigned CNT_W  = $clog2(NUM_PE) + 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                    state;
   logic [NUM_PE-1:0]         snap;
   logic [IDX_W-1:0]          idx;
   logic [PTR_W-1:0]          ptr;
   logic [MAP_W*NUM_RU-1:0]   row_map;
   logic [MAP_W*NUM_RU-1:0]   col_map;
   logic [NUM_RU-1:0]         ru_en;
   logic [CNT_W-1:0]          fault_cnt;
   logic                      overflow;
   logic                      busy_q;
   logic                      done_q;

   // Row/column of the PE currently under scan.
   logic [MAP_W-1:0]          cur_row_c;
   logic [MAP_W-1:0]          cur_col_c;
   assign cur_row_c = MAP_W'(idx / IDX_W'(COLS));
   assign cur_col_c = MAP_W'(idx % IDX_W'(COLS));

   // Allocation FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         snap      <= '0;
         idx       <= '0;
         ptr       <= '0;
         row_map   <= '0;
         col_map   <= '0;
         ru_en     <= '0;
         fault_cnt <= '0;
         overflow  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  snap      <= bus.STW_result_mat;
                  idx       <= '0;
                  ptr       <= '0;
                  row_map   <= '0;
                  col_map   <= '0;
                  ru_en     <= '0;
                  fault_cnt <= '0;
                  overflow  <= 1'b0;
                  busy_q    <= 1'b1;
                  state     <= SCAN;
               end
            end
            SCAN: begin
               if (!snap[idx]) begin
                  fault_cnt <= fault_cnt + CNT_W'(1);
                  if (ptr < PTR_W'(NUM_RU)) begin
                     for (int unsigned i = 0; i < NUM_RU; i++) begin
                        if (ptr == PTR_W'(i)) begin
                           row_map[i*MAP_W +: MAP_W] <= cur_row_c;
                           col_map[i*MAP_W +: MAP_W] <= cur_col_c;
                           ru_en[i]                  <= 1'b1;
                        end
                     end
                     ptr <= ptr + PTR_W'(1);
                  end else begin
                     overflow <= 1'b1;
                  end
               end
               idx <= idx + IDX_W'(1);
               if (idx == IDX_W'(NUM_PE - 1)) begin
                  done_q <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.ru_row_mapping = row_map;
   assign bus.ru_col_mapping = col_map;
   assign bus.ru_enable      = ru_en;
   assign bus.fault_count    = fault_cnt;
   assign bus.alloc_overflow = overflow;
   assign bus.busy           = busy_q;
   assign bus.alloc_done     = done_q;
endmodule

// File: tb/tb_fault_ru_allocator.sv
// Self-checking bench for fault_ru_allocator: directed scenarios plus random
// traffic, compared every cycle against a pass-level reference model.
module tb_fault_ru_allocator;
   localparam int unsigned ROWS   = 4;
   localparam int unsigned COLS   = 4;
   localparam int unsigned NUM_RU = 4;
   localparam int unsigned N      = ROWS * COLS;
   localparam int unsigned MW     = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fault_ru_allocator_if #(.ROWS(ROWS), .COLS(COLS), .NUM_RU(NUM_RU)) bus ();

   fault_ru_allocator #(.ROWS(ROWS), .COLS(COLS), .NUM_RU(NUM_RU)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a pass is fully described by its snapshot and the
   // number of cycles since the start was accepted.
   bit          have_pass = 0;
   int          pass_cyc  = 0;
   logic [15:0] ref_snap  = '0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // Expected outputs: faults among the PEs already processed, in index order.
   task automatic check_outputs();
      logic [7:0] e_row = '0;
      logic [7:0] e_col = '0;
      logic [3:0] e_en  = '0;
      int         n     = 0;
      int         p     = 0;
      bit         e_busy = 0;
      bit         e_done = 0;
      if (have_pass) begin
         p = (pass_cyc - 1 > int'(N)) ? int'(N) : pass_cyc - 1;
         for (int k = 0; k < p; k++) begin
            if (ref_snap[k] == 1'b0) begin
               if (n < int'(NUM_RU)) begin
                  e_row[n*MW +: MW] = 2'(k / int'(COLS));
                  e_col[n*MW +: MW] = 2'(k % int'(COLS));
                  e_en[n]           = 1'b1;
               end
               n++;
            end
         end
         e_busy = (pass_cyc <= int'(N) + 1);
         e_done = (pass_cyc == int'(N) + 1);
      end
      check_eq("ru_row_mapping", 64'(bus.ru_row_mapping), 64'(e_row));
      check_eq("ru_col_mapping", 64'(bus.ru_col_mapping), 64'(e_col));
      check_eq("ru_enable",      64'(bus.ru_enable),      64'(e_en));
      check_eq("fault_count",    64'(bus.fault_count),    64'(n));
      check_eq("alloc_overflow", 64'(bus.alloc_overflow), 64'(n > int'(NUM_RU)));
      check_eq("busy",           64'(bus.busy),           64'(e_busy));
      check_eq("alloc_done",     64'(bus.alloc_done),     64'(e_done));
   endtask

   // One clock: apply inputs, advance the model at the edge, check at negedge.
   task automatic cycle(input bit rst_v, input bit start_v, input logic [15:0] mat_v);
      rst                = rst_v;
      bus.start          = start_v;
      bus.STW_result_mat = mat_v;
      @(posedge clk);
      if (rst_v) begin
         have_pass = 0;
         pass_cyc  = 0;
      end else if (start_v && (!have_pass || pass_cyc >= int'(N) + 2)) begin
         have_pass = 1;
         pass_cyc  = 1;
         ref_snap  = mat_v;
      end else if (have_pass && pass_cyc < int'(N) + 2) begin
         pass_cyc++;
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle_cycles(input int n, input logic [15:0] mat_v);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, mat_v);
   endtask

   logic [15:0] m;

   initial begin
      bus.start          = 1'b0;
      bus.STW_result_mat = 16'hFFFF;

      // Reset held two cycles with start asserted.
      cycle(1'b1, 1'b1, 16'h0000);
      cycle(1'b1, 1'b1, 16'h0000);

      // All PEs pass.
      cycle(1'b0, 1'b1, 16'hFFFF);
      idle_cycles(18, 16'hFFFF);

      // Single fault at r=2, c=1.
      cycle(1'b0, 1'b1, 16'hFDFF);
      idle_cycles(18, 16'hFDFF);
      check_eq("single_row_final", 64'(bus.ru_row_mapping), 64'h02);
      check_eq("single_col_final", 64'(bus.ru_col_mapping), 64'h01);

      // Five faults, one more than the RU pool.
      m = 16'hFFFF & ~16'h8429;
      cycle(1'b0, 1'b1, m);
      idle_cycles(18, m);
      check_eq("five_row_final", 64'(bus.ru_row_mapping), 64'h90);
      check_eq("five_col_final", 64'(bus.ru_col_mapping), 64'h9C);
      check_eq("five_en_final",  64'(bus.ru_enable),      64'hF);

      // Snapshot isolation and start ignored mid-scan.
      cycle(1'b0, 1'b1, 16'hFDFF);
      for (int c = 1; c <= 19; c++) cycle(1'b0, c == 5, 16'h0000);
      check_eq("snap_row_final", 64'(bus.ru_row_mapping), 64'h02);
      check_eq("snap_cnt_final", 64'(bus.fault_count),    64'd1);

      // Reset in the middle of a scan, then a fresh pass.
      m = 16'hFFFF & ~16'h1001;
      cycle(1'b0, 1'b1, m);
      for (int c = 1; c <= 9; c++) cycle(c == 8, 1'b0, m);
      cycle(1'b0, 1'b1, m);
      idle_cycles(18, m);
      check_eq("rst_row_final", 64'(bus.ru_row_mapping), 64'h0C);
      check_eq("rst_col_final", 64'(bus.ru_col_mapping), 64'h00);
      check_eq("rst_cnt_final", 64'(bus.fault_count),    64'd2);

      // Random traffic: varied fault density, stray starts, occasional reset.
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 3))
            0:       m = 16'($urandom) | 16'($urandom) | 16'($urandom);
            1:       m = 16'($urandom) & 16'($urandom);
            2:       m = 16'($urandom);
            default: m = ~(16'h1 << $urandom_range(0, 15));
         endcase
         cycle($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0, m);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
